seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. One external BCD_7Seg decoder is shared across NUM_DIGITS digits. The block stores a frame of BCD digits, drives one digit code at a time to the decoder, and registers the returned segment pattern. It drives active-low anode selects with dead time between digits, applies leading-zero suppression and blanks invalid codes. It sits between the register/host logic and the display pins.

---
 rtl/seg_scan_ctrl_if.sv | 40 ++++
 rtl/seg_scan_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
// Signal bundle between the host side, the shared BCD_7Seg decoder and the
// display pins for seg_scan_ctrl.
//   enable      host -> ctrl   scan running when 1
//   load        host -> ctrl   single-cycle strobe, capture bcd_in
//   bcd_in      host -> ctrl   frame data, nibble k = digit k
//   lz_en       host -> ctrl   leading-zero suppression enable
//   seg_in      dec  -> ctrl   active-low pattern from the decoder
//   bcd_out     ctrl -> dec    digit code to the shared decoder
//   seg_out     ctrl -> pins   registered segment drive, active-low
//   an_out      ctrl -> pins   anode selects, active-low
//   frame_done  ctrl -> host   pulse at end of the last digit's ON period
//   err         ctrl -> host   sticky invalid-code flag
// slave = controller side, master = host/decoder/pins side.
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    lz_en;
    logic [6:0]              seg_in;
    logic [3:0]              bcd_out;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_done;
    logic                    err;

    modport master (
        output enable, load, bcd_in, lz_en, seg_in,
        input  bcd_out, seg_out, an_out, frame_done, err
    );

    modport slave (
        input  enable, load, bcd_in, lz_en, seg_in,
        output bcd_out, seg_out, an_out, frame_done, err
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a common-anode 7-segment display.
// A single external BCD_7Seg decoder is shared: the current digit code goes
// out on bcd_out and the decoded pattern comes back on seg_in, which is
// registered onto seg_out while the digit is lit.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high
//   bus   seg_scan_ctrl_if.slave (enable, load, bcd_in, lz_en, seg_in,
//         bcd_out, seg_out, an_out, frame_done, err)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | display dark, waiting for enable; load writes active directly
// S_DEAD | all anodes off, bcd_out already presents active[ptr]
// S_ON   | anode[ptr] low, seg_out follows seg_in (or blank)
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input logic         clk,
    input logic         rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int PTR_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DATA_W  = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      ON_LOAD   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEAD = 2'd1,
        S_ON   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       shadow_q, shadow_d;
    logic [DATA_W-1:0]       active_q, active_d;
    logic                    pending_q, pending_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_q, err_d;

    logic [3:0]              cur_code;
    logic                    upper_zero;
    logic                    code_bad;
    logic                    lz_blank;
    logic                    wrap;
    logic                    err_set;

    // Code of the digit under the pointer, and whether this digit and all
    // more significant ones are zero (leading-zero candidate).
    always_comb begin
        cur_code   = 4'd0;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (ptr_q == PTR_W'(k)) begin
                cur_code = active_q[4*k +: 4];
            end
            if ((PTR_W'(k) >= ptr_q) && (active_q[4*k +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign code_bad = (cur_code > 4'd9);
    assign lz_blank = bus.lz_en && (ptr_q != '0) && upper_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        seg_d        = SEG_BLANK;
        an_d         = AN_OFF;
        frame_done_d = 1'b0;
        err_set      = 1'b0;
        wrap         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d = S_DEAD;
                    ptr_d   = '0;
                    cnt_d   = DEAD_LOAD;
                end
            end
            S_DEAD: begin
                if (cnt_q == '0) begin
                    state_d = S_ON;
                    cnt_d   = ON_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ON: begin
                if (cnt_q == '0) begin
                    state_d = S_DEAD;
                    cnt_d   = DEAD_LOAD;
                    if (ptr_q == LAST_PTR) begin
                        ptr_d        = '0;
                        wrap         = 1'b1;
                        frame_done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable aborts the frame from any state; no frame_done for it.
        if (!bus.enable) begin
            state_d      = S_IDLE;
            ptr_d        = '0;
            cnt_d        = '0;
            wrap         = 1'b0;
            frame_done_d = 1'b0;
        end

        // Shadow -> active only at a frame boundary so a frame never tears.
        // The transfer reads the old shadow, so a load on the same edge is
        // kept pending for the next boundary.
        if (wrap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            shadow_d = bus.bcd_in;
            if (state_q == S_IDLE) begin
                active_d  = bus.bcd_in;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end

        // Entering or staying in ON: ptr_d == ptr_q, so cur_code is the lit digit.
        if (state_d == S_ON) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                an_d[k] = (ptr_d != PTR_W'(k));
            end
            if (code_bad) begin
                err_set = 1'b1;
            end else if (!lz_blank) begin
                seg_d = bus.seg_in;
            end
        end

        if (err_set) begin
            err_d = 1'b1;
        end else if (bus.load) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign bus.bcd_out    = (state_q == S_IDLE) ? 4'd0 : cur_code;
    assign bus.seg_out    = seg_q;
    assign bus.an_out     = an_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.
// The reference tracks a position within the 20-cycle frame and derives the
// lit digit and outputs from it arithmetically; a compare process checks
// every output on every cycle, and directed scenarios pin literal values.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int DC = 1;
    localparam int P  = RD + DC;
    localparam int FR = ND * P;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [6:0] dec7(input logic [3:0] c);
        case (c)
            4'd0: dec7 = 7'h40;
            4'd1: dec7 = 7'h79;
            4'd2: dec7 = 7'h24;
            4'd3: dec7 = 7'h30;
            4'd4: dec7 = 7'h19;
            4'd5: dec7 = 7'h12;
            4'd6: dec7 = 7'h02;
            4'd7: dec7 = 7'h78;
            4'd8: dec7 = 7'h00;
            4'd9: dec7 = 7'h10;
            default: dec7 = 7'h06;
        endcase
    endfunction

    always_comb bus.seg_in = dec7(bus.bcd_out);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_run;
    int          m_pos;
    logic [15:0] m_shadow, m_active;
    bit          m_pending;
    bit          m_err;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fd;
    logic [3:0]  e_bcd;

    initial begin
        logic [15:0] old_active;
        bit          old_run;
        bit          wrap;
        bit          lit;
        int          digit;
        logic [3:0]  code;
        m_run = 0; m_pos = 0; m_shadow = '0; m_active = '0; m_pending = 0; m_err = 0;
        e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0; e_bcd = 4'd0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_run = 0; m_pos = 0; m_shadow = '0; m_active = '0; m_pending = 0; m_err = 0;
                e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0; e_bcd = 4'd0;
            end else begin
                old_active = m_active;
                old_run    = m_run;
                wrap       = bus.enable && old_run && (m_pos == FR - 1);
                if (!bus.enable) begin
                    m_run = 0;
                end else if (!old_run) begin
                    m_run = 1;
                    m_pos = 0;
                end else begin
                    m_pos = (m_pos + 1) % FR;
                end
                if (!old_run && bus.load) begin
                    m_shadow  = bus.bcd_in;
                    m_active  = bus.bcd_in;
                    m_pending = 0;
                end else begin
                    if (wrap && m_pending) begin
                        m_active  = m_shadow;
                        m_pending = 0;
                    end
                    if (bus.load) begin
                        m_shadow  = bus.bcd_in;
                        m_pending = 1;
                    end
                end
                digit = m_pos / P;
                lit   = m_run && ((m_pos % P) >= DC);
                code  = old_active[4*digit +: 4];
                e_fd  = wrap;
                e_an  = 4'hF;
                e_seg = 7'h7F;
                if (lit) begin
                    e_an[digit] = 1'b0;
                    if (code <= 4'd9 &&
                        !(bus.lz_en && digit != 0 && (old_active >> (4*digit)) == 16'd0)) begin
                        e_seg = dec7(code);
                    end
                end
                if (lit && code > 4'd9) m_err = 1;
                else if (bus.load)      m_err = 0;
                e_bcd = m_run ? m_active[4*digit +: 4] : 4'd0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("an_out",     {28'd0, bus.an_out},     {28'd0, e_an});
                check("seg_out",    {25'd0, bus.seg_out},    {25'd0, e_seg});
                check("frame_done", {31'd0, bus.frame_done}, {31'd0, e_fd});
                check("err",        {31'd0, bus.err},        {31'd0, m_err});
                check("bcd_out",    {28'd0, bus.bcd_out},    {28'd0, e_bcd});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_pulse(input logic [15:0] v);
        bus.load   = 1'b1;
        bus.bcd_in = v;
        wait_edges(1);
        bus.load   = 1'b0;
    endtask

    initial begin
        int fd_cnt;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        bus.bcd_in = '0;
        bus.lz_en  = 1'b0;
        wait_edges(2);
        chk_en = 1;
        check("reset_an",  {28'd0, bus.an_out},  32'hF);
        check("reset_seg", {25'd0, bus.seg_out}, 32'h7F);
        check("reset_err", {31'd0, bus.err},     32'h0);
        rst = 1'b0;

        // basic scan
        load_pulse(16'h3210);
        bus.enable = 1'b1;
        wait_edges(2);
        check("basic_an0",  {28'd0, bus.an_out}, 32'hE);
        check("basic_seg0", {25'd0, bus.seg_out}, 32'd64);
        wait_edges(5);
        check("basic_an1",  {28'd0, bus.an_out}, 32'hD);
        check("basic_seg1", {25'd0, bus.seg_out}, 32'd121);
        wait_edges(5);
        check("basic_an2",  {28'd0, bus.an_out}, 32'hB);
        check("basic_seg2", {25'd0, bus.seg_out}, 32'd36);
        wait_edges(5);
        check("basic_an3",  {28'd0, bus.an_out}, 32'h7);
        check("basic_seg3", {25'd0, bus.seg_out}, 32'd48);
        fd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            wait_edges(1);
            if (bus.frame_done === 1'b1) fd_cnt++;
        end
        check("basic_fd_count", fd_cnt, 2);

        // tearing: now at frame position 16
        wait_edges(10);
        load_pulse(16'h9999);
        wait_edges(4);
        check("tear_seg2", {25'd0, bus.seg_out}, 32'd36);
        wait_edges(5);
        check("tear_seg3", {25'd0, bus.seg_out}, 32'd48);
        wait_edges(5);
        check("tear_new0", {25'd0, bus.seg_out}, 32'd16);

        // leading zeros
        bus.enable = 1'b0;
        wait_edges(1);
        check("idle_an", {28'd0, bus.an_out}, 32'hF);
        load_pulse(16'h0005);
        bus.lz_en  = 1'b1;
        bus.enable = 1'b1;
        wait_edges(2);
        check("lz_seg0", {25'd0, bus.seg_out}, 32'd18);
        wait_edges(5);
        check("lz_an1",  {28'd0, bus.an_out}, 32'hD);
        check("lz_seg1", {25'd0, bus.seg_out}, 32'h7F);
        wait_edges(5);
        check("lz_seg2", {25'd0, bus.seg_out}, 32'h7F);
        bus.lz_en = 1'b0;
        wait_edges(5);
        check("nolz_seg3", {25'd0, bus.seg_out}, 32'd64);

        // enable drop during digit 3 DEAD (position 15)
        wait_edges(19);
        bus.enable = 1'b0;
        wait_edges(1);
        check("drop_an", {28'd0, bus.an_out}, 32'hF);
        bus.enable = 1'b1;
        fd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            wait_edges(1);
            if (bus.frame_done === 1'b1) fd_cnt++;
        end
        check("drop_no_fd", fd_cnt, 0);
        wait_edges(1);
        check("drop_fd_after", {31'd0, bus.frame_done}, 32'h1);

        // invalid code, sticky err, reset mid-scan
        bus.enable = 1'b0;
        wait_edges(1);
        load_pulse(16'h00A0);
        bus.enable = 1'b1;
        wait_edges(2);
        check("inv_seg0", {25'd0, bus.seg_out}, 32'd64);
        wait_edges(5);
        check("inv_seg1", {25'd0, bus.seg_out}, 32'h7F);
        check("inv_err",  {31'd0, bus.err},     32'h1);
        wait_edges(20);
        check("inv_err_sticky", {31'd0, bus.err}, 32'h1);
        wait_edges(5);
        rst = 1'b1;
        wait_edges(1);
        check("rstmid_an",  {28'd0, bus.an_out},  32'hF);
        check("rstmid_seg", {25'd0, bus.seg_out}, 32'h7F);
        check("rstmid_err", {31'd0, bus.err},     32'h0);
        check("rstmid_bcd", {28'd0, bus.bcd_out}, 32'h0);
        rst = 1'b0;
        wait_edges(2);
        check("rstmid_an0",  {28'd0, bus.an_out},  32'hE);
        check("rstmid_seg0", {25'd0, bus.seg_out}, 32'd64);
        bus.enable = 1'b0;
        wait_edges(1);
        load_pulse(16'h00A0);
        bus.enable = 1'b1;
        wait_edges(7);
        check("inv2_err", {31'd0, bus.err}, 32'h1);
        bus.enable = 1'b0;
        wait_edges(1);
        check("inv2_err_idle", {31'd0, bus.err}, 32'h1);
        load_pulse(16'h0000);
        check("err_cleared", {31'd0, bus.err}, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] v;
            rst        = ($urandom_range(0, 199) == 0);
            bus.enable = ($urandom_range(0, 99) < 97);
            bus.load   = ($urandom_range(0, 99) < 8);
            for (int k = 0; k < ND; k++) begin
                int r;
                r = $urandom_range(0, 15);
                if (r < 6)       v[4*k +: 4] = 4'd0;
                else if (r < 14) v[4*k +: 4] = 4'($urandom_range(1, 9));
                else             v[4*k +: 4] = 4'($urandom_range(10, 15));
            end
            bus.bcd_in = v;
            if ($urandom_range(0, 49) == 0) bus.lz_en = ~bus.lz_en;
            wait_edges(1);
        end
        rst      = 1'b0;
        bus.load = 1'b0;
        wait_edges(1);
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
